// File: rtl/is_uart_rx_ctrl.sv
// is_uart_rx_ctrl: UART receive sequencer. Detects the start bit, samples each
// bit mid-period, checks parity/stop and holds the word in a one-entry buffer.
module is_uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 uart_rxd_r_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_err_o,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_TGT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TGT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic             PAR_ON   = (PARITY_EN != 0);
  localparam logic             PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_err_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 valid_reg;
  logic                 ferr_reg;
  logic                 perr_reg;
  logic                 ovr_reg;
  logic                 busy_reg;

  logic [CNT_W-1:0] cnt_tgt;
  logic             sample_hit;
  logic             frame_done;
  logic             accept;
  logic             par_mismatch;

  always_comb begin
    cnt_tgt      = (state_reg == S_START) ? HALF_TGT : FULL_TGT;
    sample_hit   = (cnt_reg == cnt_tgt);
    frame_done   = (state_reg == S_STOP) && sample_hit;
    accept       = valid_reg && rx_ready_i;
    par_mismatch = ((^shift_reg) ^ uart_rxd_r_i) != PAR_ODD;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      shift_reg   <= '0;
      par_err_reg <= 1'b0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
      perr_reg    <= 1'b0;
      ovr_reg     <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      ovr_reg <= 1'b0;

      // Counter idles at zero so the first START cycle starts counting from 0.
      if (state_reg == S_IDLE || state_reg == S_BREAK || sample_hit)
        cnt_reg <= '0;
      else
        cnt_reg <= cnt_reg + CNT_W'(1);

      case (state_reg)
        S_IDLE: begin
          if (!uart_rxd_r_i) begin
            state_reg <= S_START;
            busy_reg  <= 1'b1;
          end
        end
        S_START: begin
          if (sample_hit) begin
            if (uart_rxd_r_i) begin
              state_reg <= S_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= S_DATA;
              idx_reg   <= '0;
            end
          end
        end
        S_DATA: begin
          if (sample_hit) begin
            shift_reg <= {uart_rxd_r_i, shift_reg[DATA_BITS-1:1]};
            idx_reg   <= idx_reg + IDX_W'(1);
            if (idx_reg == LAST_IDX)
              state_reg <= PAR_ON ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (sample_hit) begin
            par_err_reg <= par_mismatch;
            state_reg   <= S_STOP;
          end
        end
        S_STOP: begin
          // Leaving at mid-stop-bit keeps back-to-back frames in step.
          if (sample_hit) begin
            if (uart_rxd_r_i) begin
              state_reg <= S_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (uart_rxd_r_i) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase

      // An accept in the completion cycle frees the slot for the new word.
      if (frame_done) begin
        if (!valid_reg || rx_ready_i) begin
          data_reg  <= shift_reg;
          valid_reg <= 1'b1;
          ferr_reg  <= ~uart_rxd_r_i;
          perr_reg  <= PAR_ON & par_err_reg;
        end else begin
          ovr_reg <= 1'b1;
        end
      end else if (accept) begin
        valid_reg <= 1'b0;
        ferr_reg  <= 1'b0;
        perr_reg  <= 1'b0;
      end
    end
  end

  assign rx_data_o     = data_reg;
  assign rx_valid_o    = valid_reg;
  assign frame_err_o   = ferr_reg;
  assign parity_err_o  = perr_reg;
  assign overrun_err_o = ovr_reg;
  assign busy_o        = busy_reg;

endmodule
